// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave: NUM_REGS word registers with byte strobes,
// programmable wait states, hardware-fed read-only registers and PSLVERR.
module apb_regfile_slave #(
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          ADDR_W      = 8,
  parameter int unsigned          NUM_REGS    = 4,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned BYTE_SHIFT = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'((1 << BYTE_SHIFT) - 1);

  // The setup phase is decoded straight from the bus (PSEL & !PENABLE), so the
  // register only needs to know whether the current cycle is an access phase.
  // This gives the 2+WAIT_STATES cycle transfer with PREADY combinational.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     idx_ext;
  logic                misaligned;
  logic                out_of_range;
  logic                ro_hit;
  logic                error;
  logic [DATA_W-1:0]   rd_val;
  logic                wr_commit;

  assign idx          = PADDR >> BYTE_SHIFT;
  assign idx_ext      = {1'b0, idx};
  assign misaligned   = (PADDR & LO_MASK) != '0;
  assign out_of_range = idx_ext >= (ADDR_W+1)'(NUM_REGS);
  assign error        = misaligned | out_of_range | (PWRITE & ro_hit);

  assign PREADY    = (state == ACCESS) & PSEL & PENABLE & (wait_cnt == 4'(WAIT_STATES));
  assign PSLVERR   = PREADY & error;
  assign wr_commit = PREADY & PWRITE & ~error;
  assign PRDATA    = (PREADY & ~PWRITE & ~error) ? rd_val : '0;

  // Select the addressed register's read value and read-only flag.
  always_comb begin
    ro_hit = 1'b0;
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == ADDR_W'(i)) begin
        ro_hit = RO_MASK[i];
        rd_val = RO_MASK[i] ? ro_in[i*DATA_W +: DATA_W] : regs[i];
      end
    end
  end

  // Next-state logic for the access tracker.
  always_comb begin
    state_nxt = state;
    if (!PSEL) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (!PENABLE) state_nxt = ACCESS;
        ACCESS:  if (PREADY)   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ACCESS) & PSEL & PENABLE & ~PREADY)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

  // Byte-strobed register writes on the completing edge of a good write.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VAL;
    end else if (wr_commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (idx == ADDR_W'(i) && !RO_MASK[i]) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (PSTRB[b])
              regs[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  // Register contents view: read-only slices follow the hardware inputs.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? ro_in[g*DATA_W +: DATA_W] : regs[g];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed testbench: table of APB transfers plus hand-written sequences for
// wait states, read-only tracking and reset in the middle of an access.
module tb_apb_regfile_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         psel0, psel1;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] ro_in;

  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1;
  logic         pslverr0, pslverr1;
  logic [127:0] reg_q0, reg_q1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_STATES(0),
    .RO_MASK(4'b1000), .RESET_VAL(32'h1234_5678)
  ) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .ro_in(ro_in), .reg_q(reg_q0)
  );

  apb_regfile_slave #(
    .DATA_W(32), .ADDR_W(8), .NUM_REGS(4), .WAIT_STATES(3)
  ) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .ro_in(ro_in), .reg_q(reg_q1)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full APB transfer; entered and left just after a rising edge.
  task automatic xfer(input bit which, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int ncyc);
    bit done = 1'b0;
    rd = '0; err = 1'b0;
    if (which) psel1 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    ncyc = 2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((which ? pready1 : pready0) === 1'b1) begin
        rd   = which ? prdata1  : prdata0;
        err  = which ? pslverr1 : pslverr0;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          ncyc;

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 32'h9,         4'hF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h9,         1'b0};
    vecs[3]  = '{1'b1, 8'h04, 32'h1910_2025, 4'hF, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 8'h04, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h19BB_20DD, 1'b0};
    vecs[6]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 8'h02, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h9,         1'b0};
    vecs[9]  = '{1'b0, 8'h0C, 32'h0,         4'h0, 32'h736B_614D, 1'b0};
    vecs[10] = '{1'b1, 8'h0C, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[11] = '{1'b1, 8'h08, 32'hABCD_0000, 4'h0, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[13] = '{1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[14] = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h19BB_20DD, 1'b0};

    rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    ro_in = '0;
    ro_in[127:96] = 32'h736B_614D;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready",  {31'd0, pready0},  32'd0);
    chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
    chk("rst_prdata",  prdata0,           32'd0);
    chk("rst_reg0",    reg_q0[31:0],      32'h1234_5678);
    chk("rst_dut1_reg2", reg_q1[95:64],   32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transfers on the zero-wait slave.
    for (int i = 0; i < 15; i++) begin
      xfer(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, ncyc);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_cycles", i), ncyc, 32'd2);
    end
    chk("reg_q0_after_table", reg_q0[31:0],  32'h9);
    chk("reg_q1_after_table", reg_q0[63:32], 32'h19BB_20DD);

    // Read-only slice tracks ro_in live.
    chk("ro_reg_q_init", reg_q0[127:96], 32'h736B_614D);
    ro_in[127:96] = 32'hC0FF_EE01;
    #1;
    chk("ro_reg_q_follow", reg_q0[127:96], 32'hC0FF_EE01);
    xfer(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, err, ncyc);
    chk("ro_read_new", rd, 32'hC0FF_EE01);

    // Wait states: PREADY low for three access cycles, register held until completion.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
    pwdata = 32'h666E_6150; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws_pready_c%0d", c), {31'd0, pready1}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ws_reg_c%0d", c), reg_q1[95:64], 32'h0);
      @(posedge clk); #1;
    end
    chk("ws_reg_committed", reg_q1[95:64], 32'h666E_6150);
    psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, rd, err, ncyc);
    chk("ws_readback", rd, 32'h666E_6150);
    chk("ws_read_cycles", ncyc, 32'd5);
    chk("ws_read_err", {31'd0, err}, 32'd0);

    // Reset asserted during the access phase of a write aborts it.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00;
    pwdata = 32'h55; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("mid_pready_before", {31'd0, pready0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_pready_reset", {31'd0, pready0}, 32'd0);
    chk("mid_reg0_reset", reg_q0[31:0], 32'h1234_5678);
    @(posedge clk); #1;
    chk("mid_reg0_no_commit", reg_q0[31:0], 32'h1234_5678);
    psel0 = 1'b0; penable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, ncyc);
    chk("post_rst_read", rd, 32'h1234_5678);
    chk("post_rst_cycles", ncyc, 32'd2);

    // Back-to-back: write then read with no idle cycle between.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
    pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("b2b_wr_pready", {31'd0, pready0}, 32'd1);
    @(posedge clk); #1;
    penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("b2b_rd_pready", {31'd0, pready0}, 32'd1);
    chk("b2b_rd_data", prdata0, 32'h0BAD_F00D);
    @(posedge clk); #1;
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
